// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the registered ALU: small register file, one
// command at a time, ALU result written back and returned on a response channel.
module alu_issue_ctrl #(
  parameter int NUM_REGS   = 4,
  parameter int REG_ADDR_W = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_LOAD,
  input  logic [3:0]            CMD_OP,
  input  logic [REG_ADDR_W-1:0] CMD_SRC_A,
  input  logic [REG_ADDR_W-1:0] CMD_SRC_B,
  input  logic [REG_ADDR_W-1:0] CMD_DST,
  input  logic [7:0]            CMD_DATA,
  output logic [7:0]            ALU_IN_A,
  output logic [7:0]            ALU_IN_B,
  output logic [3:0]            ALU_OP_CODE,
  input  logic [7:0]            ALU_RESULT,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [7:0]            RSP_DATA,
  output logic [REG_ADDR_W-1:0] RSP_DST
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESPOND = 2'd3;

  logic [1:0]            state;
  logic [7:0]            regs [NUM_REGS];
  logic [REG_ADDR_W-1:0] dst_q;

  assign CMD_READY = (state == IDLE);
  assign RSP_VALID = (state == RESPOND);

  // Reset has priority in every state, so a pending CAPTURE write-back is dropped.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      dst_q       <= '0;
      ALU_IN_A    <= '0;
      ALU_IN_B    <= '0;
      ALU_OP_CODE <= '0;
      RSP_DATA    <= '0;
      RSP_DST     <= '0;
      for (int unsigned i = 0; i < unsigned'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (CMD_VALID) begin
            if (CMD_LOAD) begin
              regs[CMD_DST] <= CMD_DATA;
              RSP_DATA      <= CMD_DATA;
              RSP_DST       <= CMD_DST;
              state         <= RESPOND;
            end else begin
              ALU_IN_A    <= regs[CMD_SRC_A];
              ALU_IN_B    <= regs[CMD_SRC_B];
              ALU_OP_CODE <= CMD_OP;
              dst_q       <= CMD_DST;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          regs[dst_q] <= ALU_RESULT;
          RSP_DATA    <= ALU_RESULT;
          RSP_DST     <= dst_q;
          state       <= RESPOND;
        end
        RESPOND: begin
          if (RSP_READY) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Command-driven issue controller on the initiator side of the processor ALU. It holds a small 8-bit register file, accepts one command at a time over a valid/ready handshake, and drives the ALU operand and opcode inputs. It captures the ALU's registered result one cycle later, writes it back to the destination register, and returns it on a valid/ready response channel. It sits between the processor's instruction decode and the ALU.

## Interface
- NUM_REGS, 4: register file depth; must be a power of 2.
- REG_ADDR_W, 2: register address width; equals log2(NUM_REGS).
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  reset: synchronous, active-high; clock CLK. Shared with the ALU.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  controller can accept a command.
- CMD_LOAD  in  1  1 = load immediate CMD_DATA into CMD_DST; 0 = ALU operation.
- CMD_OP  in  4  ALU opcode, passed through verbatim.
- CMD_SRC_A  in  REG_ADDR_W  register driving ALU_IN_A.
- CMD_SRC_B  in  REG_ADDR_W  register driving ALU_IN_B.
- CMD_DST  in  REG_ADDR_W  write-back register.
- CMD_DATA  in  8  immediate value for loads.
- ALU_IN_A  out  8  registered operand A to the ALU.
- ALU_IN_B  out  8  registered operand B to the ALU.
- ALU_OP_CODE  out  4  registered opcode to the ALU.
- ALU_RESULT  in  8  ALU registered output.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  consumer accepts the response.
- RSP_DATA  out  8  value written to the destination register.
- RSP_DST  out  REG_ADDR_W  destination register of the response.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESPOND. Reset state: IDLE.
- IDLE:
  - CMD_READY = 1.
  - If CMD_VALID and CMD_LOAD, then at the edge: reg[CMD_DST] <= CMD_DATA, RSP_DATA <= CMD_DATA, RSP_DST <= CMD_DST; go to RESPOND.
  - If CMD_VALID and not CMD_LOAD, then at the edge: ALU_IN_A <= reg[CMD_SRC_A], ALU_IN_B <= reg[CMD_SRC_B], ALU_OP_CODE <= CMD_OP, latch CMD_DST; go to ISSUE.
- ISSUE: ALU inputs are stable. The ALU registers its result at the end of this cycle. Go to CAPTURE.
- CAPTURE: at the edge, reg[dst] <= ALU_RESULT, RSP_DATA <= ALU_RESULT, RSP_DST <= dst; go to RESPOND.
- RESPOND: RSP_VALID = 1. When RSP_READY = 1, go to IDLE at the edge.
- CMD_READY = 1 only in IDLE. CMD_VALID in any other state is ignored. The command source holds its fields while CMD_VALID=1 and CMD_READY=0.
- ALU_IN_A, ALU_IN_B and ALU_OP_CODE hold their last issued values after the operation, until the next issue.
- Opcodes are not checked. The ALU defines the semantics:
  - 0 add, 1 sub, 2 mul, 3 shl A, 4 shr A, 5 A+1, 6 B+1, 7 A-1, 8 B-1.
  - 9 eq, A gt, B lt (unsigned, result 0x00/0x01).
  - C or, D and, E xor, F pass A.
- All arithmetic is 8-bit and wraps modulo 256. Products are truncated to the low 8 bits.
- SRC_A = SRC_B = DST is legal. Operands are read at issue, so there is no hazard; the write occurs at the CAPTURE edge.

## Timing
- Reset values:
  - CMD_READY = 1; RSP_VALID = 0.
  - RSP_DATA, RSP_DST, ALU_IN_A, ALU_IN_B = 0; ALU_OP_CODE = 4'h0.
  - All registers = 0x00.
- ALU op, accepted at edge k:
  - Cycle k+1: ISSUE.
  - Cycle k+2: CAPTURE; ALU_RESULT is valid.
  - Cycle k+3: RSP_VALID = 1.
  - Accept-to-response latency is 3 cycles.
- Load, accepted at edge k: RSP_VALID = 1 in cycle k+1. The register is readable by the next command.
- Throughput with RSP_READY tied high: one ALU op per 4 cycles, one load per 2 cycles.
- Backpressure: RSP_VALID, RSP_DATA and RSP_DST stay constant while RSP_READY = 0. There is no timeout.
- RESET in any state, including mid-operation: at that edge all state returns to reset values and any in-flight write-back is discarded. CMD_READY = 1 in the following cycle. A write that completed before the reset edge is still cleared by the reset.

## Test plan
- Reset, then LOAD r0=0x05, LOAD r1=0x03, then op 0x0 r0,r1->r2 -> RSP_DATA=0x08, RSP_DST=2, exactly 3 cycles after accept. A following op F r2->r3 returns 0x08.
- Width rules -> op 1 with r0=0x03, r1=0x05 returns 0xFE. Op 2 with 0x10, 0x10 returns 0x00. Op A with 0x80 vs 0x7F returns 0x01.
- Backpressure: hold RSP_READY=0 for 5 cycles during RESPOND while CMD_VALID=1 with a new command -> RSP_VALID and RSP_DATA stay stable and CMD_READY stays 0. The new command is accepted only in the cycle after the response handshake.
- Chained dependency: r0=0x01, then four ops 5 with SRC_A=DST=r0 -> responses 0x02, 0x03, 0x04, 0x05.
- Reset asserted during ISSUE, and separately during CAPTURE, of op 0 on r0=0x05, r1=0x03 -> RSP_VALID is never asserted and all outputs are 0 the next cycle. A subsequent op 0 r0,r1 returns 0x00.
- Back-to-back with RSP_READY high: LOAD, op, LOAD, op -> accepts at 2/4/2/4-cycle spacing and no command is dropped.
